pe_chain: RTL and testbench
===========================

# pe_chain

Parametrised successor to the single processing element: a vertical chain of `NUM_PE` signed multiply-accumulate stages sharing one mode control. It supports local accumulation, weight load and systolic partial-sum pass-down, all as in the single PE. It adds internal input skewing, a valid pipeline, saturating/shifted output narrowing, and a serial drain of the local accumulators through `bot_data_o`. It replaces hand-chained `pe_top` pairs in the array column.

## Interface
- `NUM_PE`, 4, number of chained stages (≥1)
- `WIDTH_DATA`, 16, signed operand / output width
- `WIDTH_MDATA`, 32, accumulator and partial-sum width (≥2·WIDTH_DATA)
- `OUT_SHIFT`, 0, arithmetic right shift applied before narrowing to WIDTH_DATA

- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wire_connection_i`  in  2  mode: 0 MAC, 1 LOAD, 2 SYSTOLIC, 3 HOLD
- `valid_i`  in  1  qualifies operand lanes in modes 0/1/2
- `v_bus_data_i`  in  NUM_PE·WIDTH_DATA  vertical operand, lane k = bits [k·W +: W]
- `h_bus_data_i`  in  NUM_PE·WIDTH_DATA  horizontal operand, same lane packing
- `top_data_i`  in  WIDTH_DATA  partial-sum input to stage 0, sign-extended
- `drain_i`  in  1  request serial readout of accumulators
- `bot_data_o`  out  WIDTH_DATA  registered result (systolic or drain)
- `valid_o`  out  1  bot_data_o qualifier
- `busy_o`  out  1  systolic pipeline non-empty or drain active

## Operation
- All arithmetic two's-complement signed. Products are 2·WIDTH_DATA wide, sign-extended to WIDTH_MDATA. Accumulators and partial sums wrap modulo 2^WIDTH_MDATA.
- Narrowing function N(x) = saturate(x >>> OUT_SHIFT) to [−2^(W−1), 2^(W−1)−1].
- MODE 0 (MAC), valid_i=1: acc[k] += v[k]·h[k] for every lane. valid_i=0: no change.
- MODE 1 (LOAD), valid_i=1: w[k] <= h[k]. Accumulators untouched.
- MODE 2 (SYSTOLIC), valid_i=1: inject vector. Lane k's h is delayed k cycles internally, so the caller presents a whole vector in one cycle. Stage k computes ps[k] = ps[k−1] + w[k]·h_skewed[k], with ps[−1] = sext(top_data_i) delayed 0 cycles. Each stage is registered. A per-stage valid bit travels with the data.
- MODE 3 (HOLD): no new injection, no acc/w update.
- In-flight systolic entries always flush to completion regardless of later mode changes or valid_i.
- Drain is accepted only when mode=3, busy_o=0 and drain_i=1. The acceptance cycle snapshots acc[0..NUM_PE−1] into a shift register and clears all acc to 0. The block then emits N(acc[0]) … N(acc[NUM_PE−1]) on consecutive cycles with valid_o=1.
- drain_i is ignored when not accepted. Any mode/valid_i input during drain is treated as HOLD; no inject, no MAC, no load.
- Drain FSM: IDLE → DRAIN on acceptance. In DRAIN a counter runs 0..NUM_PE−1. After the last word, DRAIN → IDLE. drain_i held high re-arms only from IDLE.

## Timing
- Reset (async assert, sync-to-clock deassert by system): acc, w, ps, skew regs, valid pipe, drain counter = 0. FSM=IDLE. bot_data_o=0, valid_o=0, busy_o=0.
- MAC/LOAD: update visible on the register one cycle after the qualifying edge. No output is produced.
- SYSTOLIC latency: a vector injected at edge t appears as bot_data_o = N(ps[NUM_PE−1]), valid_o=1, after edge t+NUM_PE. Throughput is 1 vector/cycle.
- busy_o is high from the cycle after any injection until the last valid_o of that injection, and throughout DRAIN. It is combinationally the OR of the valid-pipe bits and FSM≠IDLE.
- Drain: acceptance at edge t. Word j is on bot_data_o with valid_o=1 after edge t+1+j, j=0..NUM_PE−1. busy_o falls after edge t+NUM_PE.
- valid_o=0 → bot_data_o holds its last value.
- Systolic output and drain are mutually exclusive by construction.
- Reset mid-drain or mid-pipeline: immediate return to reset state. Partial results are discarded.

## Test plan
- MAC + drain: NUM_PE=4; mode 0, lane k v=(k+1)·i, h=i, i=1..16; mode 3, pulse drain_i -> valid_o 4 cycles with 1496, 2992, 4488, 5984; busy_o high 4 cycles; second drain -> 0,0,0,0.
- Load + systolic: mode 1 with h=20 on all lanes; mode 2, top=2i, h=i, i=1..14 back-to-back -> after 4-cycle latency, 14 consecutive valid_o with bot_data_o=82·i; busy_o drops after the last output.
- Mode change mid-flight: inject 3 vectors, switch to mode 3 next cycle -> all 3 outputs still emerge. drain_i pulsed while busy_o=1 is ignored; no drain occurs.
- Saturation: mode 0, single vector v=h=200 on lane 0, v=200/h=−200 on lane 1 -> drain gives 32767, −32768, 0, 0. With OUT_SHIFT=2 the same stimulus gives 10000, −10000.
- Reset mid-drain: assert rst_n=0 after word 1 -> bot_data_o=0, valid_o=0, busy_o=0 immediately; after release, drain -> all zeros.
- Illegal drain: drain_i in mode 0 with valid_i=1 -> MAC proceeds, no valid_o, no clear.

Source files
------------

// File: rtl/pe_chain.sv
// Chain of NUM_PE signed MAC stages: local accumulate, weight load, skewed
// systolic pass-down and serial narrowed drain of the accumulators.
module pe_chain #(
  parameter int unsigned NUM_PE      = 4,
  parameter int unsigned WIDTH_DATA  = 16,
  parameter int unsigned WIDTH_MDATA = 32,
  parameter int unsigned OUT_SHIFT   = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   wire_connection_i,
  input  logic                         valid_i,
  input  logic [NUM_PE*WIDTH_DATA-1:0] v_bus_data_i,
  input  logic [NUM_PE*WIDTH_DATA-1:0] h_bus_data_i,
  input  logic [WIDTH_DATA-1:0]        top_data_i,
  input  logic                         drain_i,
  output logic [WIDTH_DATA-1:0]        bot_data_o,
  output logic                         valid_o,
  output logic                         busy_o
);

  localparam int unsigned W  = WIDTH_DATA;
  localparam int unsigned M  = WIDTH_MDATA;
  localparam int unsigned CW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  localparam logic [1:0] MODE_MAC  = 2'd0;
  localparam logic [1:0] MODE_LOAD = 2'd1;
  localparam logic [1:0] MODE_SYS  = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  localparam logic signed [M-1:0] SAT_HI = $signed({{(M-W+1){1'b0}}, {(W-1){1'b1}}});
  localparam logic signed [M-1:0] SAT_LO = $signed({{(M-W+1){1'b1}}, {(W-1){1'b0}}});

  // Arithmetic shift then saturate into the W-bit signed output range.
  function automatic logic [W-1:0] narrow(input logic signed [M-1:0] x);
    logic signed [M-1:0] s;
    s = x >>> OUT_SHIFT;
    if (s > SAT_HI)      narrow = SAT_HI[W-1:0];
    else if (s < SAT_LO) narrow = SAT_LO[W-1:0];
    else                 narrow = s[W-1:0];
  endfunction

  logic [0:0]          state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;

  logic signed [M-1:0] acc     [NUM_PE];
  logic signed [M-1:0] ps      [NUM_PE];
  logic signed [M-1:0] snap    [NUM_PE];
  logic signed [W-1:0] w       [NUM_PE];
  logic signed [W-1:0] h_lane  [NUM_PE];
  logic signed [M-1:0] mac_ext [NUM_PE];
  logic signed [M-1:0] sys_ext [NUM_PE];
  logic signed [M-1:0] ps_in   [NUM_PE];
  logic [NUM_PE-1:0]   vp;
  logic [NUM_PE-1:0]   vin_c;

  logic idle_c, mac_c, load_c, inject_c, accept_c;

  // Every mode input is treated as HOLD while the drain is running.
  assign idle_c   = (state == ST_IDLE);
  assign mac_c    = idle_c && valid_i && (wire_connection_i == MODE_MAC);
  assign load_c   = idle_c && valid_i && (wire_connection_i == MODE_LOAD);
  assign inject_c = idle_c && valid_i && (wire_connection_i == MODE_SYS);
  assign busy_o   = (|vp) || !idle_c;
  assign accept_c = idle_c && !(|vp) && drain_i && (wire_connection_i == MODE_HOLD);

  for (genvar k = 0; k < NUM_PE; k++) begin : g_lane
    logic signed [W-1:0]   v_k;
    logic signed [W-1:0]   hs_k;
    logic signed [2*W-1:0] mp_k;
    logic signed [2*W-1:0] sp_k;

    assign v_k       = $signed(v_bus_data_i[k*W +: W]);
    assign h_lane[k] = $signed(h_bus_data_i[k*W +: W]);

    // Lane k sees its h operand k cycles late so it meets its partial sum.
    if (k == 0) begin : g_noskew
      assign hs_k = h_lane[k];
    end else begin : g_skew
      logic signed [W-1:0] dl [k];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < k; j++) dl[j] <= '0;
        end else begin
          dl[0] <= h_lane[k];
          for (int j = 1; j < k; j++) dl[j] <= dl[j-1];
        end
      end
      assign hs_k = dl[k-1];
    end

    assign mp_k       = v_k * h_lane[k];
    assign sp_k       = w[k] * hs_k;
    assign mac_ext[k] = M'(mp_k);
    assign sys_ext[k] = M'(sp_k);

    if (k == 0) begin : g_top
      assign ps_in[k] = M'($signed(top_data_i));
    end else begin : g_pass
      assign ps_in[k] = ps[k-1];
    end
  end

  always_comb begin
    vin_c    = '0;
    vin_c[0] = inject_c;
    for (int k = 1; k < NUM_PE; k++) vin_c[k] = vp[k-1];
  end

  // Drain sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = '0;
        end
      end
      ST_DRAIN: begin
        if (cnt == CW'(NUM_PE - 1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Datapath: accumulators, weights, systolic stages, snapshot, output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_PE; k++) begin
        acc[k]  <= '0;
        ps[k]   <= '0;
        snap[k] <= '0;
        w[k]    <= '0;
      end
      vp         <= '0;
      bot_data_o <= '0;
      valid_o    <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_PE; k++) begin
        if (accept_c)   acc[k] <= '0;
        else if (mac_c) acc[k] <= acc[k] + mac_ext[k];
        if (accept_c)   snap[k] <= acc[k];
        if (load_c)     w[k] <= h_lane[k];
        if (vin_c[k])   ps[k] <= ps_in[k] + sys_ext[k];
      end
      vp <= vin_c;
      if (state == ST_DRAIN) begin
        bot_data_o <= narrow(snap[cnt]);
        valid_o    <= 1'b1;
      end else if (vp[NUM_PE-1]) begin
        bot_data_o <= narrow(ps[NUM_PE-1]);
        valid_o    <= 1'b1;
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_chain.sv
// Directed bench for pe_chain: MAC+drain, load+systolic, mid-flight mode
// change, saturation (OUT_SHIFT 0 and 2), reset mid-drain, illegal drain.
module tb_pe_chain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        valid_in;
  logic [63:0] v_bus;
  logic [63:0] h_bus;
  logic [15:0] top;
  logic        drain;
  logic [15:0] bot_a, bot_b;
  logic        valid_a, valid_b, busy_a, busy_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pe_chain #(.NUM_PE(4), .WIDTH_DATA(16), .WIDTH_MDATA(32), .OUT_SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .wire_connection_i(mode), .valid_i(valid_in),
    .v_bus_data_i(v_bus), .h_bus_data_i(h_bus), .top_data_i(top), .drain_i(drain),
    .bot_data_o(bot_a), .valid_o(valid_a), .busy_o(busy_a));

  pe_chain #(.NUM_PE(4), .WIDTH_DATA(16), .WIDTH_MDATA(32), .OUT_SHIFT(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .wire_connection_i(mode), .valid_i(valid_in),
    .v_bus_data_i(v_bus), .h_bus_data_i(h_bus), .top_data_i(top), .drain_i(drain),
    .bot_data_o(bot_b), .valid_o(valid_b), .busy_o(busy_b));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_all_h(input int val);
    for (int k = 0; k < 4; k++) h_bus[k*16 +: 16] = 16'(val);
  endtask

  // Pulse drain in HOLD, then check four words, busy and the trailing idle cycle.
  task automatic drain_check(input string tag, input int ea[4], input int eb[4], input bit chk_b);
    mode = 2'd3; valid_in = 1'b0; drain = 1'b1;
    step;
    drain = 1'b0;
    check({tag, "_busy_accept"}, busy_a, 1);
    check({tag, "_valid_accept"}, valid_a, 0);
    for (int j = 0; j < 4; j++) begin
      step;
      check($sformatf("%s_valid%0d", tag, j), valid_a, 1);
      check($sformatf("%s_word%0d", tag, j), $signed(bot_a), ea[j]);
      check($sformatf("%s_busy%0d", tag, j), busy_a, (j < 3) ? 1 : 0);
      if (chk_b) check($sformatf("%s_s2word%0d", tag, j), $signed(bot_b), eb[j]);
    end
    step;
    check({tag, "_valid_after"}, valid_a, 0);
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'd3; valid_in = 1'b0; v_bus = '0; h_bus = '0;
    top = '0; drain = 1'b0;
    repeat (2) step;
    check("rst_bot", $signed(bot_a), 0);
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_busy_s2", busy_b, 0);
    rst_n = 1'b1;
    step;

    // MAC: lane k v=(k+1)i, h=i, i=1..16
    for (int i = 1; i <= 16; i++) begin
      mode = 2'd0; valid_in = 1'b1;
      for (int k = 0; k < 4; k++) v_bus[k*16 +: 16] = 16'((k + 1) * i);
      set_all_h(i);
      step;
      check("mac_no_valid", valid_a, 0);
    end
    drain_check("mac_drain", '{1496, 2992, 4488, 5984}, '{374, 748, 1122, 1496}, 1'b1);
    drain_check("mac_drain2", '{0, 0, 0, 0}, '{0, 0, 0, 0}, 1'b1);

    // Load w=20, then 14 back-to-back injections top=2i, h=i -> 82i
    mode = 2'd1; valid_in = 1'b1; v_bus = '0; set_all_h(20);
    step;
    for (int c = 1; c <= 18; c++) begin
      if (c <= 14) begin
        mode = 2'd2; valid_in = 1'b1; top = 16'(2 * c); set_all_h(c);
      end else begin
        mode = 2'd3; valid_in = 1'b0; top = '0; set_all_h(0);
      end
      step;
      if (c >= 5) begin
        check($sformatf("sys_valid_c%0d", c), valid_a, 1);
        check($sformatf("sys_out_c%0d", c), $signed(bot_a), 82 * (c - 4));
      end else begin
        check($sformatf("sys_latency_c%0d", c), valid_a, 0);
      end
      if (c == 1 || c == 17) check($sformatf("sys_busy_c%0d", c), busy_a, 1);
    end
    check("sys_busy_end", busy_a, 0);
    step;
    check("sys_valid_end", valid_a, 0);

    // Three injections then HOLD with drain requested while busy
    for (int c = 1; c <= 8; c++) begin
      if (c <= 3) begin
        mode = 2'd2; valid_in = 1'b1; top = 16'(c); set_all_h(c); drain = 1'b0;
      end else begin
        mode = 2'd3; valid_in = 1'b0; top = '0; set_all_h(0); drain = (c <= 7);
      end
      step;
      if (c >= 5 && c <= 7) begin
        check($sformatf("flush_valid_c%0d", c), valid_a, 1);
        check($sformatf("flush_out_c%0d", c), $signed(bot_a), 81 * (c - 4));
      end else if (c == 4 || c == 8) begin
        check($sformatf("flush_nodrain_c%0d", c), valid_a, 0);
      end
    end
    step;
    check("flush_idle_valid", valid_a, 0);
    check("flush_idle_busy", busy_a, 0);

    // Saturation on both shift settings
    mode = 2'd0; valid_in = 1'b1; v_bus = '0; h_bus = '0;
    v_bus[15:0] = 16'(200);  h_bus[15:0]  = 16'(200);
    v_bus[31:16] = 16'(200); h_bus[31:16] = 16'(-200);
    step;
    v_bus = '0; h_bus = '0;
    drain_check("sat", '{32767, -32768, 0, 0}, '{10000, -10000, 0, 0}, 1'b1);

    // Illegal drain during MAC: MAC proceeds, nothing emitted, nothing cleared
    for (int r = 0; r < 2; r++) begin
      mode = 2'd0; valid_in = 1'b1; drain = 1'b1;
      for (int k = 0; k < 4; k++) v_bus[k*16 +: 16] = 16'(5);
      set_all_h(5);
      step;
      check($sformatf("illegal_valid%0d", r), valid_a, 0);
      check($sformatf("illegal_busy%0d", r), busy_a, 0);
    end
    drain = 1'b0; v_bus = '0; h_bus = '0;
    drain_check("illegal_drain", '{50, 50, 50, 50}, '{12, 12, 12, 12}, 1'b1);

    // Reset mid-drain
    mode = 2'd0; valid_in = 1'b1;
    for (int k = 0; k < 4; k++) v_bus[k*16 +: 16] = 16'(3);
    set_all_h(3);
    step;
    mode = 2'd3; valid_in = 1'b0; drain = 1'b1;
    step;
    drain = 1'b0;
    step;
    check("rd_word0", $signed(bot_a), 9);
    step;
    check("rd_word1", $signed(bot_a), 9);
    check("rd_busy_pre", busy_a, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rd_bot", $signed(bot_a), 0);
    check("rd_valid", valid_a, 0);
    check("rd_busy", busy_a, 0);
    step;
    rst_n = 1'b1;
    step;
    check("rd_idle_valid", valid_a, 0);
    drain_check("rd_drain", '{0, 0, 0, 0}, '{0, 0, 0, 0}, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
